// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter with grant lock while the owner holds req,
// plus an optional hold timeout that forces a release after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant_oh,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout,
  output logic [IDXW-1:0] ptr_out
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state_q;
  logic [N-1:0]    grant_oh_q;
  logic [IDXW-1:0] grant_idx_q, ptr_q, ptr_d, win, j;
  logic [CNTW-1:0] hold_cnt_q;
  logic            grant_valid_q, timeout_q, lim, rel;
  // Scan downward so the requester closest above ptr is written last and wins.
  always_comb begin
    win = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDXW'((int'(ptr_q) + k) % N);
      if (req[j]) win = j;
    end
  end
  assign lim   = (MAX_HOLD != 0) && (hold_cnt_q == CNTW'(MAX_HOLD));
  assign rel   = !req[grant_idx_q] || lim;
  assign ptr_d = (grant_idx_q == IDXW'(N - 1)) ? '0 : grant_idx_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_oh_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
    end else if (state_q == IDLE) begin
      timeout_q <= 1'b0;
      if (|req) begin
        grant_oh_q    <= {{(N-1){1'b0}}, 1'b1} << win;
        grant_idx_q   <= win;
        grant_valid_q <= 1'b1;
        hold_cnt_q    <= CNTW'(1);
        state_q       <= GRANT;
      end
    end else if (rel) begin
      grant_oh_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= lim && req[grant_idx_q];
      ptr_q         <= ptr_d;
      state_q       <= IDLE;
    end else begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end
  assign grant_oh    = grant_oh_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;
  assign ptr_out     = ptr_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed bench; expected grant/release events are queued by
// the stimulus and popped by a negedge monitor that watches grant_valid edges.
module tb_rr_arbiter8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] grant_oh;
  logic [2:0] grant_idx, ptr_out;
  logic       grant_valid, timeout;

  rr_arbiter8 #(.N(8), .IDXW(3), .MAX_HOLD(4), .CNTW(5)) dut (
    .clk(clk), .rst(rst), .req(req), .grant_oh(grant_oh), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .timeout(timeout), .ptr_out(ptr_out)
  );

  always #5 clk = ~clk;

  typedef struct {bit rel; int idx; int ptr; bit to; int dur; int gap;} exp_t;
  exp_t q[$];
  int vec = 0, miss = 0;

  task automatic chk(string nm, int act, int want);
    vec++;
    if (act != want) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t g(int idx, int gap);
    exp_t e = '{0, idx, 0, 0, 0, gap};
    return e;
  endfunction

  function automatic exp_t r(int idx, int ptr, bit to, int dur);
    exp_t e = '{1, idx, ptr, to, dur, -1};
    return e;
  endfunction

  // Monitor: per-cycle invariants plus scoreboard on grant/release edges.
  logic pv = 1'b0;
  int   dur = 0, gap = 0;
  always @(negedge clk) begin
    exp_t e;
    chk("invariants", int'((grant_valid != |grant_oh) || ($countones(grant_oh) > 1) ||
        (grant_valid && !grant_oh[grant_idx]) || (timeout && grant_valid)), 0);
    if (grant_valid != pv) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = q.pop_front();
        chk("event_kind", int'(pv), int'(e.rel));
        chk(e.rel ? "rel_idx" : "grant_idx", int'(grant_idx), e.idx);
        if (e.rel) begin
          chk("rel_ptr", int'(ptr_out), e.ptr);
          chk("rel_timeout", int'(timeout), int'(e.to));
          chk("rel_hold_cycles", dur, e.dur);
        end else begin
          chk("grant_oh", int'(grant_oh), 1 << e.idx);
          if (e.gap >= 0) chk("grant_gap", gap, e.gap);
        end
      end
    end
    dur = grant_valid ? (pv ? dur + 1 : 1) : 0;
    gap = grant_valid ? 0 : (pv ? 1 : gap + 1);
    pv  = grant_valid;
  end

  initial begin
    // Reset then single request
    tick(2);
    chk("rst_oh", int'(grant_oh), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_ptr", int'(ptr_out), 0);
    rst = 1'b0;
    req = 8'h04;
    q.push_back(g(2, -1));
    tick(2);
    req = 8'h00;
    q.push_back(r(2, 3, 0, 2));
    tick(3);
    // Rotation fairness from ptr 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      q.push_back(g(i % 8, (i == 0) ? -1 : 1));
      tick(3);
      req = 8'hFF & ~(8'h01 << (i % 8));
      q.push_back(r(i % 8, (i + 1) % 8, 0, 3));
      tick(1);
      req = 8'hFF;
    end
    req = 8'h00;
    tick(2);
    // Park ptr at 6, then wrap-around scan 6,7,0
    req = 8'h20;
    q.push_back(g(5, -1));
    tick(1);
    req = 8'h00;
    q.push_back(r(5, 6, 0, 1));
    tick(1);
    req = 8'h21;
    q.push_back(g(0, 1));
    tick(1);
    req = 8'h20;
    q.push_back(r(0, 1, 0, 1));
    q.push_back(g(5, 1));
    tick(2);
    // Lock-out while 5 owns the grant
    req = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("lock_idx", int'(grant_idx), 5);
      chk("lock_oh", int'(grant_oh), 8'h20);
    end
    req = 8'hDF;
    q.push_back(r(5, 6, 0, 3));
    tick(1);
    req = 8'h00;
    tick(2);
    // Timeout with MAX_HOLD = 4 from ptr 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 8'h09;
    q.push_back(g(0, -1));
    q.push_back(r(0, 1, 1, 4));
    q.push_back(g(3, 1));
    q.push_back(r(3, 4, 1, 4));
    q.push_back(g(0, 1));
    q.push_back(r(0, 1, 1, 4));
    tick(15);
    req = 8'h00;
    tick(3);
    // Mid-grant reset
    req = 8'h10;
    q.push_back(g(4, -1));
    tick(1);
    rst = 1'b1;
    q.push_back(r(0, 0, 0, 1));
    tick(1);
    chk("mrst_oh", int'(grant_oh), 0);
    chk("mrst_valid", int'(grant_valid), 0);
    chk("mrst_ptr", int'(ptr_out), 0);
    chk("mrst_timeout", int'(timeout), 0);
    rst = 1'b0;
    q.push_back(g(4, 1));
    tick(1);
    chk("post_rst_idx", int'(grant_idx), 4);
    req = 8'h00;
    q.push_back(r(4, 5, 0, 1));
    tick(1);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    tick(2);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among N requesters. It uses the 8-to-3 priority-encode function, rotated by a fairness pointer.
- Grant is locked while the owner holds its request, with an optional hold-timeout.
- Sits in front of a shared datapath and drives its select lines: grant_idx feeds a mux, grant_oh feeds enables.

Parameters:
- N, 8, number of requesters; legal range 2..8.
- IDXW, 3, width of grant_idx; must equal ceil(log2(N)).
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the timeout.
- CNTW, 5, width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- grant_oh  output  N  one-hot grant, registered.
- grant_idx  output  IDXW  binary index of the granted requester, registered.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- ptr_out  output  IDXW  current round-robin priority pointer (debug/verification).

Behaviour:
- Reset: synchronous active-high, sampled on the rising clk edge. Reset value of every output and internal register is 0:
  - grant_oh, grant_idx, grant_valid, timeout, ptr_out = 0;
  - state = IDLE, hold_cnt = 0.
  - rst asserted mid-grant drops the grant at that edge, with no timeout pulse.
- Two-state FSM: IDLE, GRANT.
- IDLE:
  - If req == 0, stay in IDLE; outputs hold their reset values.
  - Else the winner is the first set req bit scanning upward from ptr, wrapping N-1 -> 0.
  - Next edge: grant_oh = one-hot(winner), grant_idx = winner, grant_valid = 1, hold_cnt = 1, state = GRANT.
  - Latency is one cycle from req sampled to grant visible.
- GRANT, release conditions (either one):
  - (a) req[grant_idx] == 0 sampled: normal release.
  - (b) MAX_HOLD != 0 and hold_cnt == MAX_HOLD: forced release; timeout = 1 for exactly the next cycle.
- GRANT, on release at the next edge:
  - grant_oh = 0, grant_valid = 0;
  - grant_idx holds its last value;
  - ptr = (grant_idx + 1) mod N;
  - state = IDLE.
- GRANT, otherwise: hold_cnt increments; the grant is unchanged.
- Guaranteed gap: every release produces exactly one grant_valid = 0 cycle before the next grant.
- Other requesters' req changes during GRANT are ignored until the owner releases. No preemption other than timeout.
- ptr is updated only on release. Wrap example for N = 8: idx 7 -> ptr 0.
- If N < 8, unused index values never appear.
- Timed-out requester that still asserts req: it gets lowest priority next round (ptr is past it). It may be re-granted only if no other req bit is set.
- Simultaneous release and new requests: new requests are evaluated in the IDLE cycle against the updated ptr.
- Invariants:
  - grant_oh is one-hot or zero;
  - grant_valid == |grant_oh;
  - grant_oh[grant_idx] == 1 whenever grant_valid;
  - timeout is never high while grant_valid is high.

Test Plan:
- Reset then single request: rst = 1 for 2 cycles, then req = 8'b0000_0100 → cycle after: grant_idx = 2, grant_oh = 8'h04, grant_valid = 1. Drop req → next cycle grant_valid = 0, ptr_out = 3.
- Rotation fairness: req = 8'hFF held; each owner drops req for 1 cycle after 3 cycles of grant. Required grant order 0,1,2,…,7,0 with a 1-cycle gap between grants; ptr_out wraps 7 → 0.
- Pointer wrap-around: ptr = 6, req = 8'b0010_0001 → grant_idx = 0 (scan 6,7,0). After release ptr_out = 1, and the next winner is 5.
- Timeout: MAX_HOLD = 4, req = 8'b0000_1001 held constant from ptr 0:
  - grant 0 held 4 cycles, then grant_valid = 0 with timeout = 1 for one cycle;
  - next grant_idx = 3;
  - after 3's timeout, grant_idx = 0.
- Lock-out: grant to 5 active; assert req = 8'hFF mid-grant → grant_idx stays 5 until req[5] drops. No change in grant_oh before then.
- Mid-grant reset: grant_idx = 4 active, assert rst 1 cycle → next edge all outputs 0, ptr_out = 0, timeout = 0. With req = 8'h10 after reset, grant_idx = 4 one cycle after rst deasserts.
